// File: rtl/adder_pkg.sv
// ============================================================================
// adder_pkg
// Shared widths and word type for the modified carry-select adder.
// Rev 1.0
// ============================================================================
`default_nettype none

package adder_pkg;
  localparam int WIDTH   = 32;
  localparam int GROUP   = 4;
  localparam int NGROUPS = WIDTH / GROUP;

  typedef logic [WIDTH-1:0] word_t;
endpackage

`default_nettype wire

// File: rtl/csla_bec_group4.sv
// ============================================================================
// csla_bec_group4
// One carry-select group: RCA with cin=0, excess-1 converter, 2:1 select mux.
// Rev 1.0
// ============================================================================
`default_nettype none

module csla_bec_group4
  import adder_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin_sel,
  output logic [GROUP-1:0] s,
  output logic             cout
);
  logic [GROUP-1:0] w_s0;
  logic [GROUP-1:0] w_s1;
  logic             w_c0;
  logic             w_c1;

  rca4 u_rca (
    .a    (a),
    .b    (b),
    .s    (w_s0),
    .cout (w_c0)
  );

  // BEC sees only the RCA result, so cin_sel touches nothing but the mux
  assign w_s1[0] = ~w_s0[0];
  assign w_s1[1] = w_s0[1] ^ w_s0[0];
  assign w_s1[2] = w_s0[2] ^ (w_s0[1] & w_s0[0]);
  assign w_s1[3] = w_s0[3] ^ (w_s0[2] & w_s0[1] & w_s0[0]);
  assign w_c1    = w_c0 | (w_s0[3] & w_s0[2] & w_s0[1] & w_s0[0]);

  assign s    = cin_sel ? w_s1 : w_s0;
  assign cout = cin_sel ? w_c1 : w_c0;
endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// full_adder
// Single-bit gate-level full adder.
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);
endmodule

`default_nettype wire

// File: rtl/rca4.sv
// ============================================================================
// rca4
// 4-bit ripple-carry adder of full_adder cells, carry-in tied to zero.
// Rev 1.0
// ============================================================================
`default_nettype none

module rca4
  import adder_pkg::*;
(
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  output logic [GROUP-1:0] s,
  output logic             cout
);
  logic [GROUP:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < GROUP; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i]),
      .s    (s[i]),
      .cout (w_c[i+1])
    );
  end

  assign cout = w_c[GROUP];
endmodule

`default_nettype wire

// File: rtl/bit_modified_carry_gate_level.sv
// ============================================================================
// bit_modified_carry_gate_level
// 32-bit modified carry-select adder with registered sum and carry-out.
// Rev 1.0
// ============================================================================
`default_nettype none

module bit_modified_carry_gate_level
  import adder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  word_t            sum_d;
  word_t            sum_q;
  logic             cout_q;
  logic [NGROUPS:1] w_carry;

  rca4 u_g0 (
    .a    (a[GROUP-1:0]),
    .b    (b[GROUP-1:0]),
    .s    (sum_d[GROUP-1:0]),
    .cout (w_carry[1])
  );

  // Carry chain: G0 ripple, then one mux per group
  for (genvar k = 1; k < NGROUPS; k++) begin : g_grp
    csla_bec_group4 u_grp (
      .a       (a[k*GROUP +: GROUP]),
      .b       (b[k*GROUP +: GROUP]),
      .cin_sel (w_carry[k]),
      .s       (sum_d[k*GROUP +: GROUP]),
      .cout    (w_carry[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= w_carry[NGROUPS];
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

`default_nettype wire

// File: tb/tb_bit_modified_carry_gate_level.sv
// ============================================================================
// tb_bit_modified_carry_gate_level
// Directed and random self-checking bench for the registered 32-bit CSLA.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bit_modified_carry_gate_level;
  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic        cout;

  int errors;
  int checks;

  bit_modified_carry_gate_level dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    #2;
    checks++;
    if ({cout, sum} !== 33'h0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", {cout, sum}, 33'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cout, sum} !== 33'h0) begin
      errors++;
      $display("FAIL reset_held got=%h exp=%h", {cout, sum}, 33'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [31:0] va   [6];
    logic [31:0] vb   [6];
    logic [32:0] vexp [6];
    va[0] = 32'h00000001; vb[0] = 32'h00000001; vexp[0] = {1'b0, 32'h00000002};
    va[1] = 32'hFFFF0006; vb[1] = 32'h12560006; vexp[1] = {1'b1, 32'h1255000C};
    va[2] = 32'h0909FEEF; vb[2] = 32'hFEDFFEEF; vexp[2] = {1'b1, 32'h07E9FDDE};
    va[3] = 32'hFFFFFFFF; vb[3] = 32'h00000001; vexp[3] = {1'b1, 32'h00000000};
    va[4] = 32'hFEFEF1EF; vb[4] = 32'hFEFEF1EF; vexp[4] = {1'b1, 32'hFDFDE3DE};
    va[5] = 32'h00110110; vb[5] = 32'h11000110; vexp[5] = {1'b0, 32'h11110220};
    for (int i = 0; i < 6; i++) begin
      a = va[i];
      b = vb[i];
      @(posedge clk);
      #1;
      checks++;
      if ({cout, sum} !== vexp[i]) begin
        errors++;
        $display("FAIL vector%0d a=%h b=%h got=%h exp=%h", i, va[i], vb[i], {cout, sum}, vexp[i]);
      end
    end
  endtask

  task automatic test_reset_pulse();
    a = 32'hFFFFFFFF;
    b = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    checks++;
    if ({cout, sum} !== {1'b1, 32'hFFFFFFFE}) begin
      errors++;
      $display("FAIL pulse_pre got=%h exp=%h", {cout, sum}, {1'b1, 32'hFFFFFFFE});
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cout, sum} !== 33'h0) begin
      errors++;
      $display("FAIL pulse_clear got=%h exp=%h", {cout, sum}, 33'h0);
    end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({cout, sum} !== 33'h0) begin
      errors++;
      $display("FAIL pulse_release got=%h exp=%h", {cout, sum}, 33'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cout, sum} !== {1'b1, 32'hFFFFFFFE}) begin
      errors++;
      $display("FAIL pulse_first_edge got=%h exp=%h", {cout, sum}, {1'b1, 32'hFFFFFFFE});
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp_v;
    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'h80000000;
      if (i == 0) b = 32'h80000000;
      exp_v = {1'b0, a} + {1'b0, b};
      @(posedge clk);
      #1;
      checks++;
      if ({cout, sum} !== exp_v) begin
        errors++;
        $display("FAIL b2b%0d got=%h exp=%h", i, {cout, sum}, exp_v);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    a      = '0;
    b      = '0;
    test_reset();
    test_vectors();
    test_reset_pulse();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
